// File: rtl/eh2_dec_trigger_csr_if.sv
// eh2_dec_trigger_csr_if: trigger packet type and CSR access bus between TLU and trigger bank.
package eh2_trigger_pkg;
    typedef struct packed {
        logic        select;
        logic        match;
        logic        store;
        logic        load;
        logic        execute;
        logic        m;
        logic [31:0] tdata2;
    } eh2_trigger_pkt_t;
endpackage

interface eh2_dec_trigger_csr_if;
    logic        csr_wr_en;
    logic        csr_rd_en;
    logic        csr_tid;
    logic [11:0] csr_addr;
    logic [31:0] csr_wrdata;
    logic [31:0] csr_rddata;
    logic        csr_rd_valid;
    modport master (output csr_wr_en, csr_rd_en, csr_tid, csr_addr, csr_wrdata,
                    input  csr_rddata, csr_rd_valid);
    modport slave  (input  csr_wr_en, csr_rd_en, csr_tid, csr_addr, csr_wrdata,
                    output csr_rddata, csr_rd_valid);
endinterface

// File: rtl/eh2_dec_trigger_csr.sv
// eh2_dec_trigger_csr: per-thread mtsel/mtdata1/mtdata2 bank for four debug triggers,
// with debug-mode write protection, chain/action legality and retired-hit recording.
module eh2_dec_trigger_csr
    import eh2_trigger_pkg::*;
#(
    parameter int NUM_THREADS = 2
) (
    input  logic                               clk,
    input  logic                               rst_l,
    eh2_dec_trigger_csr_if.slave               csr,
    input  logic [NUM_THREADS-1:0]             dbg_mode,
    input  logic [NUM_THREADS-1:0][3:0]        trigger_hit,
    output eh2_trigger_pkt_t [NUM_THREADS-1:0][3:0] trigger_pkt_any,
    output logic [NUM_THREADS-1:0][1:0]        trigger_chain,
    output logic [NUM_THREADS-1:0][3:0]        trigger_action
);
    localparam logic [11:0] ADDR_MTSEL   = 12'h7A0;
    localparam logic [11:0] ADDR_MTDATA1 = 12'h7A1;
    localparam logic [11:0] ADDR_MTDATA2 = 12'h7A2;

    typedef struct packed {
        logic        dmode;
        logic        hit;
        logic        select;
        logic        action;
        logic        chain;
        logic        match;
        logic        m;
        logic        execute;
        logic        store;
        logic        load;
        logic [31:0] tdata2;
    } trig_t;

    trig_t       trig_q  [NUM_THREADS][4];
    trig_t       trig_d  [NUM_THREADS][4];
    logic [1:0]  mtsel_q [NUM_THREADS];
    logic [1:0]  mtsel_d [NUM_THREADS];
    logic [31:0] rddata_q, rddata_d;
    logic        rd_valid_q;
    logic        tid;
    logic [1:0]  sel, psel;
    trig_t       cur;
    logic        locked, new_dmode, wr1, wr2;
    logic [31:0] wd;

    assign tid = (NUM_THREADS > 1) ? csr.csr_tid : 1'b0;
    assign wd  = csr.csr_wrdata;

    always_comb begin
        sel       = mtsel_q[tid];
        psel      = {sel[1], 1'b0};
        cur       = trig_q[tid][sel];
        locked    = cur.dmode & ~dbg_mode[tid];
        new_dmode = dbg_mode[tid] & wd[27];
        wr1       = csr.csr_wr_en & (csr.csr_addr == ADDR_MTDATA1) & ~locked;
        wr2       = csr.csr_wr_en & (csr.csr_addr == ADDR_MTDATA2) & ~locked;
        trig_d    = trig_q;
        mtsel_d   = mtsel_q;
        for (int t = 0; t < NUM_THREADS; t++)
            for (int i = 0; i < 4; i++)
                if (trigger_hit[t][i]) trig_d[t][i].hit = 1'b1;
        if (csr.csr_wr_en && csr.csr_addr == ADDR_MTSEL) mtsel_d[tid] = wd[1:0];
        // An accepted write's hit bit overrides a same-cycle hit pulse on that trigger.
        if (wr1) begin
            trig_d[tid][sel].dmode   = new_dmode;
            trig_d[tid][sel].hit     = wd[20];
            trig_d[tid][sel].select  = wd[19];
            trig_d[tid][sel].action  = wd[12] & new_dmode;
            trig_d[tid][sel].chain   = wd[11] & ~sel[0];
            trig_d[tid][sel].match   = wd[7];
            trig_d[tid][sel].m       = wd[6];
            trig_d[tid][sel].execute = wd[2];
            trig_d[tid][sel].store   = wd[1];
            trig_d[tid][sel].load    = wd[0];
            if (sel[0] && new_dmode && !trig_q[tid][psel].dmode && trig_q[tid][psel].chain)
                trig_d[tid][psel].chain = 1'b0;
        end
        if (wr2) trig_d[tid][sel].tdata2 = wd;
        rddata_d = !csr.csr_rd_en ? rddata_q :
                   (csr.csr_addr == ADDR_MTSEL)   ? {30'b0, sel} :
                   (csr.csr_addr == ADDR_MTDATA1) ? {4'h2, cur.dmode, 6'h1F, cur.hit, cur.select,
                                                     6'b0, cur.action, cur.chain, 3'b0, cur.match,
                                                     cur.m, 3'b0, cur.execute, cur.store, cur.load} :
                   (csr.csr_addr == ADDR_MTDATA2) ? cur.tdata2 : 32'b0;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                mtsel_q[t] <= 2'b0;
                for (int i = 0; i < 4; i++) trig_q[t][i] <= '0;
            end
            rddata_q   <= 32'b0;
            rd_valid_q <= 1'b0;
        end else begin
            trig_q     <= trig_d;
            mtsel_q    <= mtsel_d;
            rddata_q   <= rddata_d;
            rd_valid_q <= csr.csr_rd_en;
        end
    end

    assign csr.csr_rddata   = rddata_q;
    assign csr.csr_rd_valid = rd_valid_q;

    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            for (int i = 0; i < 4; i++) begin
                trigger_pkt_any[t][i] = '{select:  trig_q[t][i].select,  match: trig_q[t][i].match,
                                          store:   trig_q[t][i].store,   load:  trig_q[t][i].load,
                                          execute: trig_q[t][i].execute, m:     trig_q[t][i].m,
                                          tdata2:  trig_q[t][i].tdata2};
                trigger_action[t][i]  = trig_q[t][i].action;
            end
            trigger_chain[t] = {trig_q[t][2].chain, trig_q[t][0].chain};
        end
    end
endmodule

// File: tb/tb_eh2_dec_trigger_csr.sv
// tb_eh2_dec_trigger_csr: directed checks of the trigger CSR bank with hand-computed values.
module tb_eh2_dec_trigger_csr;
    import eh2_trigger_pkg::*;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    logic [1:0]      dbg_mode = '0;
    logic [1:0][3:0] hit = '0;
    eh2_trigger_pkt_t [1:0][3:0] pkt;
    logic [1:0][1:0] chain;
    logic [1:0][3:0] action;
    int n_cmp = 0;
    int n_bad = 0;

    eh2_dec_trigger_csr_if bus();

    eh2_dec_trigger_csr #(.NUM_THREADS(2)) dut (
        .clk(clk), .rst_l(rst_l), .csr(bus), .dbg_mode(dbg_mode), .trigger_hit(hit),
        .trigger_pkt_any(pkt), .trigger_chain(chain), .trigger_action(action)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic tid, input logic [11:0] a, input logic [31:0] d);
        bus.csr_wr_en = 1'b1; bus.csr_tid = tid; bus.csr_addr = a; bus.csr_wrdata = d;
        cyc();
        bus.csr_wr_en = 1'b0;
    endtask

    task automatic rd(input string tag, input logic tid, input logic [11:0] a, input logic [31:0] exp);
        bus.csr_rd_en = 1'b1; bus.csr_tid = tid; bus.csr_addr = a;
        cyc();
        bus.csr_rd_en = 1'b0;
        check({tag, "_data"}, 64'(bus.csr_rddata), 64'(exp));
        check({tag, "_vld"}, 64'(bus.csr_rd_valid), 64'd1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_vld"}, 64'(bus.csr_rd_valid), 64'd0);
        check({tag, "_data"}, 64'(bus.csr_rddata), 64'd0);
        check({tag, "_pkt_t0"}, 64'(pkt[0]), 64'd0);
        check({tag, "_pkt_t1"}, 64'(pkt[1]), 64'd0);
        check({tag, "_chain"}, 64'(chain), 64'd0);
        check({tag, "_action"}, 64'(action), 64'd0);
    endtask

    initial begin
        bus.csr_wr_en = 1'b0; bus.csr_rd_en = 1'b0; bus.csr_tid = 1'b0;
        bus.csr_addr = '0; bus.csr_wrdata = '0;
        #12;
        check_reset("rst");
        rst_l = 1'b1;
        cyc();
        rd("rst_mtdata1", 0, 12'h7A1, 32'h23E00000);
        cyc();
        check("rd_valid_drop", 64'(bus.csr_rd_valid), 64'd0);

        wr(0, 12'h7A0, 32'hFFFF_FFF2);
        wr(0, 12'h7A1, 32'h00080845);
        wr(0, 12'h7A2, 32'h80001000);
        check("pkt02", 64'(pkt[0][2]), {26'b0, 6'b100111, 32'h80001000});
        check("chain_t2", 64'(chain[0]), 64'b10);
        rd("mtsel2", 0, 12'h7A0, 32'h2);
        rd("t2_mtdata1", 0, 12'h7A1, 32'h23E80845);
        wr(0, 12'h7A0, 32'h3);
        wr(0, 12'h7A1, 32'h00080845);
        rd("t3_chain0", 0, 12'h7A1, 32'h23E80045);

        wr(0, 12'h7A0, 32'h0);
        dbg_mode = 2'b01;
        wr(0, 12'h7A1, 32'h08001044);
        dbg_mode = 2'b00;
        rd("dmode_set", 0, 12'h7A1, 32'h2BE01044);
        wr(0, 12'h7A1, 32'h0);
        wr(0, 12'h7A2, 32'h55);
        rd("lock_mtdata1", 0, 12'h7A1, 32'h2BE01044);
        check("lock_tdata2", 64'(pkt[0][0].tdata2), 64'd0);
        wr(0, 12'h7A0, 32'h1);
        wr(0, 12'h7A1, 32'h00001044);
        rd("action_illegal", 0, 12'h7A1, 32'h23E00044);
        check("action_vec", 64'(action[0]), 64'b0001);

        dbg_mode = 2'b01;
        wr(0, 12'h7A0, 32'h3);
        wr(0, 12'h7A1, 32'h08000000);
        dbg_mode = 2'b00;
        check("partner_chain_clr", 64'(chain[0]), 64'b00);

        hit[1][3] = 1'b1;
        cyc();
        hit = '0;
        wr(1, 12'h7A0, 32'h3);
        rd("hit_t1", 1, 12'h7A1, 32'h23F00000);
        rd("hit_t0_clean", 0, 12'h7A1, 32'h2BE00000);
        hit[1][3] = 1'b1;
        wr(1, 12'h7A1, 32'h00000004);
        hit = '0;
        rd("hit_wr_wins", 1, 12'h7A1, 32'h23E00004);
        wr(0, 12'h7A0, 32'h0);
        hit[0][0] = 1'b1;
        wr(0, 12'h7A1, 32'h0);
        hit = '0;
        rd("hit_blocked", 0, 12'h7A1, 32'h2BF01044);
        hit[1][0] = 1'b1;
        wr(1, 12'h7A2, 32'hABCD);
        hit = '0;
        check("other_wr", 64'(pkt[1][3].tdata2), 64'hABCD);
        wr(1, 12'h7A0, 32'h0);
        rd("other_hit", 1, 12'h7A1, 32'h23F00000);

        wr(0, 12'h7A0, 32'h2);
        bus.csr_rd_en = 1'b1;
        wr(0, 12'h7A2, 32'h1234);
        bus.csr_rd_en = 1'b0;
        check("coll_old", 64'(bus.csr_rddata), 64'h80001000);
        rd("coll_new", 0, 12'h7A2, 32'h1234);
        rd("unknown", 0, 12'h7A5, 32'h0);

        bus.csr_rd_en = 1'b1; bus.csr_addr = 12'h7A1;
        #3 rst_l = 1'b0;
        cyc();
        bus.csr_rd_en = 1'b0;
        check_reset("arst");
        #2 rst_l = 1'b1;
        cyc();
        rd("arst_mtsel", 0, 12'h7A0, 32'h0);
        rd("arst_mtdata2", 0, 12'h7A2, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
